// File: rtl/bus_arbiter4.sv
// -----------------------------------------------------------------------------
// bus_arbiter4
//
// Round-robin owner arbiter for the shared 32-bit datapath bus. It drives the
// select/enable pins of the 4-to-1 bus multiplexer and guarantees at least one
// idle (undriven) cycle between consecutive owners. A hold counter forcibly
// releases an owner that keeps the bus for MAX_HOLD consecutive cycles.
//
// Parameters:
//   MAX_HOLD  maximum consecutive cycles one owner may hold the bus (1..255)
//
// Ports:
//   clk      in   1  system clock, rising edge active
//   rst_n    in   1  asynchronous active-low reset
//   req      in   4  level-sensitive bus request, bit i = source i
//   done     in   4  end-of-transfer, only the current owner's bit is honoured
//   select   out  2  mux select, binary index of the current owner
//   enable   out  1  mux output enable, high only while a source owns the bus
//   grant    out  4  one-hot grant, 1 << select while enable is high, else 0
//   busy     out  1  copy of enable for the control unit
//   timeout  out  1  one-cycle pulse after a release forced by MAX_HOLD
// -----------------------------------------------------------------------------
module bus_arbiter4 #(
    parameter int MAX_HOLD = 15
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] req,
    input  logic [3:0] done,
    output logic [1:0] select,
    output logic       enable,
    output logic [3:0] grant,
    output logic       busy,
    output logic       timeout
);

    // Counter just wide enough to reach MAX_HOLD.
    localparam int CNT_W = (MAX_HOLD < 2) ? 1 : $clog2(MAX_HOLD + 1);
    localparam logic [CNT_W-1:0] HOLD_LIM = CNT_W'(MAX_HOLD);

    typedef enum logic {
        IDLE = 1'b0,
        OWN  = 1'b1
    } state_t;

    state_t           state;
    state_t           state_n;
    logic [1:0]       owner_n;
    logic [1:0]       ptr;
    logic [1:0]       ptr_n;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_n;
    logic             enable_n;
    logic [3:0]       grant_n;
    logic             timeout_n;

    logic             rel_done;
    logic             rel_drop;
    logic             rel_hold;

    // First set request bit searching ptr, ptr+1, ptr+2, ptr+3 (mod 4).
    function automatic logic [1:0] rr_pick(input logic [3:0] r, input logic [1:0] p);
        logic [1:0] idx;
        logic [1:0] pick;
        logic       found;
        pick  = p;
        found = 1'b0;
        for (int i = 0; i < 4; i++) begin
            idx = p + 2'(i);
            if (!found && r[idx]) begin
                pick  = idx;
                found = 1'b1;
            end
        end
        return pick;
    endfunction

    // The select register doubles as the owner index; it keeps its last value
    // while idle, which is harmless because enable gates the mux.
    assign rel_done = done[select];
    assign rel_drop = ~req[select];
    assign rel_hold = (cnt == HOLD_LIM);

    // Next-state and next-output logic.
    always_comb begin
        state_n   = state;
        owner_n   = select;
        ptr_n     = ptr;
        cnt_n     = cnt;
        timeout_n = 1'b0;

        case (state)
            IDLE: begin
                // Requests are sampled only here, which both enforces the
                // turnaround cycle and gives the round-robin its fairness.
                if (|req) begin
                    state_n = OWN;
                    owner_n = rr_pick(req, ptr);
                    cnt_n   = CNT_W'(1);
                end
            end
            OWN: begin
                if (rel_done || rel_drop || rel_hold) begin
                    state_n   = IDLE;
                    ptr_n     = select + 2'd1;
                    cnt_n     = '0;
                    // A forced release only counts when the owner had not
                    // finished on its own in the same cycle.
                    timeout_n = rel_hold && !rel_done && !rel_drop;
                end else begin
                    cnt_n = cnt + CNT_W'(1);
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase

        enable_n = (state_n == OWN);
        grant_n  = enable_n ? (4'b0001 << owner_n) : 4'b0000;
    end

    // State and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            ptr     <= 2'd0;
            cnt     <= '0;
            select  <= 2'd0;
            enable  <= 1'b0;
            grant   <= 4'b0000;
            timeout <= 1'b0;
        end else begin
            state   <= state_n;
            ptr     <= ptr_n;
            cnt     <= cnt_n;
            select  <= owner_n;
            enable  <= enable_n;
            grant   <= grant_n;
            timeout <= timeout_n;
        end
    end

    assign busy = enable;

endmodule

// File: tb/tb_bus_arbiter4.sv
// -----------------------------------------------------------------------------
// tb_bus_arbiter4
//
// Directed bench for bus_arbiter4 with MAX_HOLD = 15. A behavioural model
// tracks owner/pointer/hold-time as plain integers and is compared with the
// DUT on every falling edge; literal expectations pin the model as well.
// -----------------------------------------------------------------------------
module tb_bus_arbiter4;

    localparam int MAX = 15;

    logic       clk;
    logic       rst_n;
    logic [3:0] req;
    logic [3:0] done;
    logic [1:0] select;
    logic       enable;
    logic [3:0] grant;
    logic       busy;
    logic       timeout;

    int n_checks = 0;
    int n_pass   = 0;

    bus_arbiter4 #(.MAX_HOLD(MAX)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     (req),
        .done    (done),
        .select  (select),
        .enable  (enable),
        .grant   (grant),
        .busy    (busy),
        .timeout (timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- behavioural model ----------------
    int m_owner = -1;   // -1 = bus free
    int m_ptr   = 0;
    int m_held  = 0;
    int m_to    = 0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_owner = -1;
            m_ptr   = 0;
            m_held  = 0;
            m_to    = 0;
        end else if (m_owner < 0) begin
            m_to = 0;
            for (int k = 0; k < 4; k++) begin
                if (m_owner < 0 && req[(m_ptr + k) % 4]) begin
                    m_owner = (m_ptr + k) % 4;
                    m_held  = 1;
                end
            end
        end else begin
            if (done[m_owner] || !req[m_owner] || m_held == MAX) begin
                m_to    = (m_held == MAX && !done[m_owner] && req[m_owner]) ? 1 : 0;
                m_ptr   = (m_owner + 1) % 4;
                m_owner = -1;
                m_held  = 0;
            end else begin
                m_held = m_held + 1;
                m_to   = 0;
            end
        end
    end

    // ---------------- continuous compare ----------------
    always @(negedge clk) begin
        logic [3:0] e_grant;
        logic       e_en;
        logic       ok;
        e_en    = (m_owner >= 0);
        e_grant = e_en ? (4'b0001 << m_owner) : 4'b0000;
        ok = (enable == e_en) && (busy == e_en) && (grant == e_grant) &&
             (timeout == (m_to != 0)) && (!e_en || select == 2'(m_owner));
        n_checks++;
        if (ok) n_pass++;
        else $display("FAIL model t=%0t: got en=%b busy=%b sel=%0d gnt=%b to=%b, want en=%b gnt=%b owner=%0d to=%0d",
                      $time, enable, busy, select, grant, timeout, e_en, e_grant, m_owner, m_to);
    end

    // ---------------- directed stimulus ----------------
    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, want %0d", name, act, exp);
    endtask

    task automatic step(input int n = 1);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        step(2);
        rst_n = 1'b1;
    endtask

    int exp_seq [9] = '{1, 0, 2, 0, 4, 0, 8, 0, 1};
    int n_hi;

    initial begin
        rst_n = 1'b0;
        req   = 4'b0000;
        done  = 4'b0000;
        step(2);
        chk("reset_enable", enable, 0);
        chk("reset_grant",  grant,  0);
        chk("reset_select", select, 0);
        rst_n = 1'b1;

        // Reset mid-grant clears outputs asynchronously.
        req = 4'b0001;
        step();
        chk("pre_reset_grant", grant, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_enable",  enable,  0);
        chk("async_rst_grant",   grant,   0);
        chk("async_rst_busy",    busy,    0);
        chk("async_rst_timeout", timeout, 0);
        step();
        req   = 4'b0000;
        rst_n = 1'b1;
        step();

        // Single request, done on OWN cycle 3.
        req = 4'b0100;
        step();
        chk("single_select", select, 2);
        chk("single_grant",  grant,  4);
        chk("single_enable", enable, 1);
        step(2);
        done = 4'b0100;
        step();
        chk("single_release_en", enable,  0);
        chk("single_release_to", timeout, 0);
        done = 4'b0000;
        req  = 4'b0000;
        step();
        // done in IDLE has no effect
        done = 4'b1111;
        step(2);
        chk("idle_done_ignored", enable, 0);
        done = 4'b0000;

        // Round robin from ptr = 0.
        do_reset();
        req  = 4'b1111;
        done = 4'b1111;
        for (int i = 0; i < 9; i++) begin
            step();
            chk($sformatf("rr_grant_%0d", i), grant, exp_seq[i]);
        end
        req  = 4'b0000;
        done = 4'b0000;
        step(2);

        // Wrap: owner 2 releases leaving ptr = 3.
        do_reset();
        req = 4'b0100;
        step();
        chk("wrap_owner2", grant, 4);
        req = 4'b1001;
        step();
        chk("wrap_idle", enable, 0);
        step();
        chk("wrap_grant3", grant, 8);
        req = 4'b0001;
        step();
        chk("wrap_idle2", enable, 0);
        step();
        chk("wrap_grant0", grant, 1);
        req = 4'b0000;
        step(2);

        // Timeout: source 1 holds forever.
        req = 4'b0010;
        step();
        n_hi = 0;
        while (enable && n_hi < 40) begin
            n_hi++;
            step();
        end
        chk("timeout_hold_cycles", n_hi, MAX);
        chk("timeout_pulse",       timeout, 1);
        chk("timeout_idle_en",     enable,  0);
        step();
        chk("timeout_regrant",     grant,   2);
        chk("timeout_pulse_end",   timeout, 0);
        req = 4'b0000;
        step(2);

        // Simultaneous done at the hold limit; non-owner done ignored.
        req  = 4'b0010;
        done = 4'b1000;
        step();
        for (int k = 1; k <= MAX; k++) begin
            if (k == 1 || k == MAX) chk($sformatf("sim_retain_%0d", k), grant, 2);
            if (k == MAX) done = 4'b1010;
            step();
        end
        chk("sim_release_en", enable,  0);
        chk("sim_release_to", timeout, 0);
        req  = 4'b0000;
        done = 4'b0000;
        step(2);

        // Request drop: ptr = 2 so 0011 picks source 0.
        req = 4'b0011;
        step();
        chk("drop_owner0", grant, 1);
        req = 4'b0010;
        step();
        chk("drop_idle", enable, 0);
        step();
        chk("drop_grant1", grant, 2);
        req = 4'b0000;
        step(3);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
